// File: rtl/wakeup_broadcast_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wakeup_broadcast_arbiter
// Purpose  : Buffers FU1/FU2/FU3 results in per-FU FIFOs and round-robin
//            broadcasts one result per cycle on the wakeup/ROB-complete bus.
// Revision : 1.0 - initial release
// ============================================================================
module wakeup_broadcast_arbiter #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fu1_done,
    input  logic [TAG_W-1:0] fu1_tag,
    input  logic [31:0]      fu1_val,
    input  logic [ROB_W-1:0] fu1_rob,
    input  logic             fu2_done,
    input  logic [TAG_W-1:0] fu2_tag,
    input  logic [31:0]      fu2_val,
    input  logic [ROB_W-1:0] fu2_rob,
    input  logic             fu3_done,
    input  logic [TAG_W-1:0] fu3_tag,
    input  logic [31:0]      fu3_val,
    input  logic [ROB_W-1:0] fu3_rob,
    output logic             FU1_ready,
    output logic             FU2_ready,
    output logic             FU3_ready,
    output logic             wakeup_valid,
    output logic [TAG_W-1:0] wakeup_tag,
    output logic [31:0]      wakeup_val,
    output logic [ROB_W-1:0] wakeup_rob,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + 32 + ROB_W;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [2:0]    w_done;
    logic [2:0]    w_ready;
    logic [2:0]    w_nonempty;
    logic [2:0]    w_pop;
    logic [EW-1:0] w_entry [3];
    logic [EW-1:0] w_head  [3];
    logic          w_grant_valid;
    logic [1:0]    w_grant_idx;
    logic [EW-1:0] w_grant_data;

    logic [1:0]    rr_q;
    logic          wakeup_valid_q;
    logic [EW-1:0] wakeup_q;
    logic          overflow_q;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    assign w_done     = {fu3_done, fu2_done, fu1_done};
    assign w_entry[0] = {fu1_tag, fu1_val, fu1_rob};
    assign w_entry[1] = {fu2_tag, fu2_val, fu2_rob};
    assign w_entry[2] = {fu3_tag, fu3_val, fu3_rob};

    for (genvar n = 0; n < 3; n++) begin : g_fifo
        logic [EW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wr_q;
        logic [PW-1:0] rd_q;
        logic [CW-1:0] cnt_q;
        logic          w_push;

        // Ready looks only at the registered count, never at a same-cycle pop.
        assign w_ready[n]    = (cnt_q < C_FULL);
        assign w_nonempty[n] = (cnt_q != '0);
        assign w_push        = w_done[n] & w_ready[n];
        assign w_pop[n]      = w_grant_valid && (w_grant_idx == 2'(n));
        assign w_head[n]     = mem_q[rd_q];

        always_ff @(posedge clk) begin
            if (w_push && !flush) begin
                mem_q[wr_q] <= w_entry[n];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (w_push) begin
                    wr_q <= wr_q + PW'(1);
                end
                if (w_pop[n]) begin
                    rd_q <= rd_q + PW'(1);
                end
                cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop[n]);
            end
        end
    end

    // Scan from the farthest candidate back to rr_q so the nearest one wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        w_grant_data  = '0;
        for (int k = 2; k >= 0; k--) begin
            if (w_nonempty[wrap3({1'b0, rr_q} + 3'(k))]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = wrap3({1'b0, rr_q} + 3'(k));
                w_grant_data  = w_head[wrap3({1'b0, rr_q} + 3'(k))];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wakeup_valid_q <= 1'b0;
            wakeup_q       <= '0;
            rr_q           <= 2'd0;
            overflow_q     <= 1'b0;
        end else if (flush) begin
            wakeup_valid_q <= 1'b0;
            wakeup_q       <= '0;
            rr_q           <= 2'd0;
        end else begin
            wakeup_valid_q <= w_grant_valid;
            wakeup_q       <= w_grant_data;
            if (w_grant_valid) begin
                rr_q <= wrap3({1'b0, w_grant_idx} + 3'd1);
            end
            if (|(w_done & ~w_ready)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign FU1_ready    = w_ready[0];
    assign FU2_ready    = w_ready[1];
    assign FU3_ready    = w_ready[2];
    assign wakeup_valid = wakeup_valid_q;
    assign wakeup_tag   = wakeup_q[EW-1 -: TAG_W];
    assign wakeup_val   = wakeup_q[ROB_W +: 32];
    assign wakeup_rob   = wakeup_q[ROB_W-1:0];
    assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_wakeup_broadcast_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wakeup_broadcast_arbiter
// Purpose  : Directed + randomized self-checking bench against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wakeup_broadcast_arbiter;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int ROB_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic fu1_done, fu2_done, fu3_done;
    logic [TAG_W-1:0] fu1_tag, fu2_tag, fu3_tag;
    logic [31:0]      fu1_val, fu2_val, fu3_val;
    logic [ROB_W-1:0] fu1_rob, fu2_rob, fu3_rob;
    logic FU1_ready, FU2_ready, FU3_ready;
    logic wakeup_valid, overflow;
    logic [TAG_W-1:0] wakeup_tag;
    logic [31:0]      wakeup_val;
    logic [ROB_W-1:0] wakeup_rob;

    always #5 clk = ~clk;

    wakeup_broadcast_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu1_done(fu1_done), .fu1_tag(fu1_tag), .fu1_val(fu1_val), .fu1_rob(fu1_rob),
        .fu2_done(fu2_done), .fu2_tag(fu2_tag), .fu2_val(fu2_val), .fu2_rob(fu2_rob),
        .fu3_done(fu3_done), .fu3_tag(fu3_tag), .fu3_val(fu3_val), .fu3_rob(fu3_rob),
        .FU1_ready(FU1_ready), .FU2_ready(FU2_ready), .FU3_ready(FU3_ready),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .wakeup_val(wakeup_val),
        .wakeup_rob(wakeup_rob), .overflow(overflow)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
        logic [ROB_W-1:0] rob;
    } ent_t;

    ent_t mq [3][$];
    ent_t m_ent;
    bit   m_valid;
    int   m_rr;
    bit   m_ovf;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [TAG_W-1:0] bc_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_valid = 1'b0;
        m_ent   = '0;
        m_rr    = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held across it.
    task automatic model_update();
        ent_t e [3];
        bit   d [3];
        bit   rdy [3];
        int   g;
        e[0] = '{fu1_tag, fu1_val, fu1_rob};
        e[1] = '{fu2_tag, fu2_val, fu2_rob};
        e[2] = '{fu3_tag, fu3_val, fu3_rob};
        d[0] = fu1_done; d[1] = fu2_done; d[2] = fu3_done;
        if (flush) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 1'b0;
            m_ent   = '0;
            m_rr    = 0;
            return;
        end
        for (int i = 0; i < 3; i++) rdy[i] = (mq[i].size() < DEPTH);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_rr + k) % 3;
            if (g < 0 && mq[i].size() > 0) g = i;
        end
        if (g >= 0) begin
            m_ent   = mq[g].pop_front();
            m_valid = 1'b1;
            m_rr    = (g + 1) % 3;
        end else begin
            m_ent   = '0;
            m_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (d[i]) begin
                if (rdy[i]) mq[i].push_back(e[i]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("wakeup_bus",
              {19'd0, wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob},
              {19'd0, m_valid, m_ent.tag, m_ent.val, m_ent.rob});
        check("ready_overflow",
              {60'd0, overflow, FU3_ready, FU2_ready, FU1_ready},
              {60'd0, m_ovf, mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH});
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_update();
        else model_reset();
        @(negedge clk);
        compare_all();
        if (wakeup_valid) bc_log.push_back(wakeup_tag);
    endtask

    task automatic idle();
        flush = 1'b0;
        fu1_done = 1'b0; fu2_done = 1'b0; fu3_done = 1'b0;
        fu1_tag = '0; fu2_tag = '0; fu3_tag = '0;
        fu1_val = '0; fu2_val = '0; fu3_val = '0;
        fu1_rob = '0; fu2_rob = '0; fu3_rob = '0;
    endtask

    task automatic push(input int fu, input int tag, input logic [31:0] val, input int rob);
        case (fu)
            0: begin fu1_done = 1'b1; fu1_tag = TAG_W'(tag); fu1_val = val; fu1_rob = ROB_W'(rob); end
            1: begin fu2_done = 1'b1; fu2_tag = TAG_W'(tag); fu2_val = val; fu2_rob = ROB_W'(rob); end
            default: begin fu3_done = 1'b1; fu3_tag = TAG_W'(tag); fu3_val = val; fu3_rob = ROB_W'(rob); end
        endcase
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        step();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        idle();
        model_reset();
        #12;
        check("reset_valid", {63'd0, wakeup_valid}, 64'd0);
        check("reset_tag", {58'd0, wakeup_tag}, 64'd0);
        check("reset_ready", {61'd0, FU3_ready, FU2_ready, FU1_ready}, 64'd7);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single FU2 result: one cycle of latency, then idle.
        push(1, 10, 32'h1, 15);
        step();
        idle();
        step();
        check("t1_valid", {63'd0, wakeup_valid}, 64'd1);
        check("t1_tag", {58'd0, wakeup_tag}, 64'd10);
        check("t1_val", {32'd0, wakeup_val}, 64'd1);
        check("t1_rob", {58'd0, wakeup_rob}, 64'd15);
        step();
        check("t1_idle_valid", {63'd0, wakeup_valid}, 64'd0);
        check("t1_idle_tag", {58'd0, wakeup_tag}, 64'd0);

        // Fairness: three simultaneous results drain in FU order.
        do_flush();
        push(0, 20, 32'h20, 1); push(1, 21, 32'h21, 2); push(2, 22, 32'h22, 3);
        step();
        idle();
        step(); check("t2_first", {58'd0, wakeup_tag}, 64'd20);
        step(); check("t2_second", {58'd0, wakeup_tag}, 64'd21);
        step(); check("t2_third", {58'd0, wakeup_tag}, 64'd22);
        step(); check("t2_idle", {63'd0, wakeup_valid}, 64'd0);

        // Round-robin: FIFO1 {1,2}, FIFO3 {3} gives 1,3,2.
        do_flush();
        push(0, 1, 32'h11, 4); push(2, 3, 32'h33, 6);
        step();
        idle();
        push(0, 2, 32'h22, 5);
        step(); check("t3_first", {58'd0, wakeup_tag}, 64'd1);
        idle();
        step(); check("t3_second", {58'd0, wakeup_tag}, 64'd3);
        step(); check("t3_third", {58'd0, wakeup_tag}, 64'd2);
        step(); check("t3_idle", {63'd0, wakeup_valid}, 64'd0);

        // Back-pressure: FIFO1 fills on the sixth push, seventh is dropped.
        do_flush();
        bc_log.delete();
        for (int c = 0; c < 7; c++) begin
            idle();
            push(0, 30 + c, 32'h300 + c, c);
            if (c < 4) begin
                push(1, 40 + c, 32'h400 + c, c);
                push(2, 50 + c, 32'h500 + c, c);
            end
            step();
            if (c == 5) begin
                check("t4_fu1_not_ready", {63'd0, FU1_ready}, 64'd0);
                check("t4_no_overflow_yet", {63'd0, overflow}, 64'd0);
            end
            if (c == 6) check("t4_overflow", {63'd0, overflow}, 64'd1);
        end
        idle();
        for (int c = 0; c < 20; c++) step();
        seen = 0;
        foreach (bc_log[i]) begin
            if (bc_log[i] >= 30 && bc_log[i] <= 36) begin
                check("t4_fu1_order", {58'd0, bc_log[i]}, 64'(30 + seen));
                seen++;
            end
        end
        check("t4_fu1_count", 64'(seen), 64'd6);

        // Flush with buffered FIFO2 results.
        do_flush();
        for (int c = 0; c < 3; c++) begin
            push(1, 60 + c, 32'h600 + c, c);
            step();
        end
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_valid", {63'd0, wakeup_valid}, 64'd0);
        check("t5_ready", {61'd0, FU3_ready, FU2_ready, FU1_ready}, 64'd7);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t5_quiet", {63'd0, wakeup_valid}, 64'd0);
        end

        // Asynchronous reset while broadcasting.
        push(0, 7, 32'h77, 7); push(1, 8, 32'h88, 8);
        step();
        idle();
        step();
        check("t6_pre_valid", {63'd0, wakeup_valid}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_bus", {19'd0, wakeup_valid, wakeup_tag, wakeup_val, wakeup_rob}, 64'd0);
        check("t6_async_overflow", {63'd0, overflow}, 64'd0);
        model_reset();
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("t6_quiet", {63'd0, wakeup_valid}, 64'd0);
        end

        // Randomized traffic, heavy enough to fill FIFOs, with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            idle();
            flush = ($urandom_range(0, 39) == 0);
            for (int f = 0; f < 3; f++) begin
                if ($urandom_range(0, 99) < 45)
                    push(f, int'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 63)));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
